vga_fb_scheduler: RTL and testbench

Owns the single asynchronous SRAM port shared between VGA scanout and a framebuffer writer. It is driven by the pixel column/row counters. During the visible area it issues one display read per cycle. During blanking it grants the bus to a valid/ready writer, and it inserts bus-turnaround cycles between read and write phases. It sits between the pixel address generator, the SRAM pad logic, and the colour output stage.

---
 rtl/vga_fb_scheduler_pkg.sv | 32 +++
 rtl/vga_fb_scheduler_if.sv | 35 +++
 rtl/vga_fb_scheduler_window.sv | 42 ++++
 rtl/vga_fb_scheduler.sv | 173 +++++++++++++++++
 tb/tb_vga_fb_scheduler.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_fb_scheduler_pkg.sv
// Shared types for the VGA framebuffer SRAM scheduler: bus-phase states and
// the SRAM control-pin encoding for each phase.
package vga_fb_scheduler_pkg;

    // Bus phase owned by the scheduler in a given cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } sched_state_e;

    // SRAM control pins (strobes active-low, pad drive active-high).
    typedef struct packed {
        logic oe_n;
        logic we_n;
        logic data_oe;
    } pad_ctrl_t;

    localparam pad_ctrl_t PAD_IDLE  = '{oe_n: 1'b1, we_n: 1'b1, data_oe: 1'b0};
    localparam pad_ctrl_t PAD_READ  = '{oe_n: 1'b0, we_n: 1'b1, data_oe: 1'b0};
    localparam pad_ctrl_t PAD_WRITE = '{oe_n: 1'b1, we_n: 1'b0, data_oe: 1'b1};

    // Control-pin pattern driven while the bus is in the given phase.
    function automatic pad_ctrl_t pad_ctrl_for(input sched_state_e s);
        case (s)
            ST_READ:  return PAD_READ;
            ST_WRITE: return PAD_WRITE;
            default:  return PAD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/vga_fb_scheduler_if.sv
// Writer handshake plus SRAM pad bus around the framebuffer scheduler.
// The slave modport is the scheduler's view; master is the environment
// (writer and SRAM pad logic).
interface vga_fb_scheduler_if #(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 16
) ();

    // Framebuffer writer (valid/ready, no buffering inside the scheduler)
    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;

    // Asynchronous SRAM port
    logic [ADDR_BITS-1:0] sram_addr;
    logic                 sram_we_n;
    logic                 sram_oe_n;
    logic [DATA_BITS-1:0] sram_data_out;
    logic                 sram_data_oe;
    logic [DATA_BITS-1:0] sram_data_in;

    modport slave (
        input  wr_valid, wr_addr, wr_data, sram_data_in,
        output wr_ready, sram_addr, sram_we_n, sram_oe_n,
               sram_data_out, sram_data_oe
    );

    modport master (
        output wr_valid, wr_addr, wr_data, sram_data_in,
        input  wr_ready, sram_addr, sram_we_n, sram_oe_n,
               sram_data_out, sram_data_oe
    );

endinterface

// File: rtl/vga_fb_scheduler_window.sv
// vga_fb_window: purely combinational decode of the pixel counters into
// "visible", "a write may start now" and the scanout read address.
module vga_fb_window #(
    parameter int H_VISIBLE     = 640,
    parameter int V_VISIBLE     = 480,
    parameter int H_WHOLE_LINE  = 800,
    parameter int V_WHOLE_FRAME = 525,
    parameter int ADDR_BITS     = 20,
    parameter int GUARD         = 2,
    parameter int COL_BITS      = $clog2(H_WHOLE_LINE),
    parameter int ROW_BITS      = $clog2(V_WHOLE_FRAME)
) (
    input  logic [COL_BITS-1:0]  column,
    input  logic [ROW_BITS-1:0]  row,
    output logic                 vis,
    output logic                 write_ok,
    output logic [ADDR_BITS-1:0] rd_addr
);

    localparam logic [COL_BITS-1:0] COL_VIS_END     = COL_BITS'(H_VISIBLE);
    localparam logic [COL_BITS-1:0] COL_GUARD_START = COL_BITS'(H_WHOLE_LINE - GUARD);
    localparam logic [ROW_BITS-1:0] ROW_VIS_END     = ROW_BITS'(V_VISIBLE);
    localparam logic [ROW_BITS-1:0] ROW_LAST        = ROW_BITS'(V_WHOLE_FRAME - 1);

    logic [ROW_BITS-1:0] next_row;
    logic                in_guard;

    assign vis = (column < COL_VIS_END) && (row < ROW_VIS_END);

    // Row that follows once this line ends; wraps at the frame end.
    assign next_row = (row == ROW_LAST) ? '0 : row + ROW_BITS'(1);

    // The last GUARD columns before a visible line are closed to new writes,
    // so a write issued here can never collide with the first scanout read.
    assign in_guard = (column >= COL_GUARD_START) && (next_row < ROW_VIS_END);

    assign write_ok = !vis && !in_guard;

    // Linear framebuffer address; deliberately truncated to ADDR_BITS.
    assign rd_addr = ADDR_BITS'(row) * ADDR_BITS'(H_VISIBLE) + ADDR_BITS'(column);

endmodule

// File: rtl/vga_fb_scheduler.sv
// vga_fb_scheduler: arbitrates the single SRAM port between VGA scanout
// (one read per visible pixel) and a valid/ready framebuffer writer that is
// only served in blanking, with a turnaround cycle between read and write.
// Decisions use cycle-t inputs; pad outputs are registered at t+1 and read
// pixels are returned at t+2.

// Fallback mode constants when the shared vga_mode header is not in the build.
`ifndef VGA_MODE_H_WHOLE_LINE
`define VGA_MODE_H_WHOLE_LINE 800
`endif
`ifndef VGA_MODE_V_WHOLE_FRAME
`define VGA_MODE_V_WHOLE_FRAME 525
`endif

module vga_fb_scheduler
    import vga_fb_scheduler_pkg::*;
#(
    parameter int H_VISIBLE     = 640,
    parameter int V_VISIBLE     = 480,
    parameter int H_WHOLE_LINE  = `VGA_MODE_H_WHOLE_LINE,
    parameter int V_WHOLE_FRAME = `VGA_MODE_V_WHOLE_FRAME,
    parameter int ADDR_BITS     = 20,
    parameter int DATA_BITS     = 16,
    parameter int GUARD         = 2,
    parameter int COL_BITS      = $clog2(H_WHOLE_LINE),
    parameter int ROW_BITS      = $clog2(V_WHOLE_FRAME)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COL_BITS-1:0]  column,
    input  logic [ROW_BITS-1:0]  row,
    vga_fb_scheduler_if.slave    bus,
    output logic [DATA_BITS-1:0] disp_pixel,
    output logic                 disp_valid
);

    // ------------------------------------------------------------------
    // Window decode
    // ------------------------------------------------------------------
    logic                 vis;
    logic                 write_ok;
    logic [ADDR_BITS-1:0] rd_addr;

    vga_fb_window #(
        .H_VISIBLE     (H_VISIBLE),
        .V_VISIBLE     (V_VISIBLE),
        .H_WHOLE_LINE  (H_WHOLE_LINE),
        .V_WHOLE_FRAME (V_WHOLE_FRAME),
        .ADDR_BITS     (ADDR_BITS),
        .GUARD         (GUARD),
        .COL_BITS      (COL_BITS),
        .ROW_BITS      (ROW_BITS)
    ) u_window (
        .column   (column),
        .row      (row),
        .vis      (vis),
        .write_ok (write_ok),
        .rd_addr  (rd_addr)
    );

    // ------------------------------------------------------------------
    // Bus-phase FSM
    // ------------------------------------------------------------------
    sched_state_e state_q, state_d;
    logic         wr_ready;
    logic         wr_accept;

    // Next bus phase and writer handshake from this cycle's counters.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        // A cycle that follows a read is the turnaround cycle: never accept.
        wr_ready  = write_ok && (state_q != ST_READ);
        wr_accept = wr_ready && bus.wr_valid;

        if (vis) begin
            state_d = ST_READ;
        end else begin
            case (state_q)
                ST_READ:  state_d = ST_IDLE;
                ST_IDLE:  state_d = wr_accept ? ST_WRITE : ST_IDLE;
                ST_WRITE: state_d = wr_accept ? ST_WRITE : ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Bus-phase register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state is updated with non-blocking assignments so
        // every register samples the pre-edge values of its inputs.
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered SRAM pad outputs
    // ------------------------------------------------------------------
    pad_ctrl_t            ctrl_q, ctrl_d;
    logic [ADDR_BITS-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_BITS-1:0] sram_data_out_q, sram_data_out_d;

    // Pad values for the phase just decided; address/data hold when unused.
    always_comb begin
        ctrl_d          = pad_ctrl_for(state_d);
        sram_addr_d     = sram_addr_q;
        sram_data_out_d = sram_data_out_q;
        case (state_d)
            ST_READ: begin
                sram_addr_d = rd_addr;
            end
            ST_WRITE: begin
                sram_addr_d     = bus.wr_addr;
                sram_data_out_d = bus.wr_data;
            end
            default: begin
            end
        endcase
    end

    // Pad registers; asynchronous reset releases the strobes at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q          <= PAD_IDLE;
            sram_addr_q     <= '0;
            sram_data_out_q <= '0;
        end else begin
            ctrl_q          <= ctrl_d;
            sram_addr_q     <= sram_addr_d;
            sram_data_out_q <= sram_data_out_d;
        end
    end

    // ------------------------------------------------------------------
    // Display return path
    // ------------------------------------------------------------------
    logic                 disp_valid_q, disp_valid_d;
    logic [DATA_BITS-1:0] disp_pixel_q, disp_pixel_d;

    // While a read is on the pads the SRAM answers within the cycle; capture it.
    always_comb begin
        disp_valid_d = (state_q == ST_READ);
        disp_pixel_d = disp_valid_d ? bus.sram_data_in : disp_pixel_q;
    end

    // Pixel return registers; valid drops immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_valid_q <= 1'b0;
            disp_pixel_q <= '0;
        end else begin
            disp_valid_q <= disp_valid_d;
            disp_pixel_q <= disp_pixel_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.wr_ready      = wr_ready;
    assign bus.sram_addr     = sram_addr_q;
    assign bus.sram_oe_n     = ctrl_q.oe_n;
    assign bus.sram_we_n     = ctrl_q.we_n;
    assign bus.sram_data_oe  = ctrl_q.data_oe;
    assign bus.sram_data_out = sram_data_out_q;
    assign disp_pixel        = disp_pixel_q;
    assign disp_valid        = disp_valid_q;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Bench for vga_fb_scheduler: directed counter sequences, a per-cycle
// transaction-history model of the SRAM bus, and hand-computed spot checks.
module tb_vga_fb_scheduler;

    localparam int H_VIS = 640;
    localparam int V_VIS = 480;
    localparam int H_TOT = 800;
    localparam int V_TOT = 525;
    localparam int GRD   = 2;
    localparam int AW    = 20;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [9:0]    column = 10'd700;
    logic [9:0]    row = 10'd500;
    logic [DW-1:0] disp_pixel;
    logic          disp_valid;

    vga_fb_scheduler_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

    vga_fb_scheduler #(
        .H_VISIBLE     (H_VIS),
        .V_VISIBLE     (V_VIS),
        .H_WHOLE_LINE  (H_TOT),
        .V_WHOLE_FRAME (V_TOT),
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW),
        .GUARD         (GRD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .column     (column),
        .row        (row),
        .bus        (bus),
        .disp_pixel (disp_pixel),
        .disp_valid (disp_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t col=%0d row=%0d)",
                     name, act, exp, $time, column, row);
        end
    endtask

    // ---------------- reference model (rules, not structure) ----------------
    function automatic bit m_vis(input int c, input int r);
        return (c < H_VIS) && (r < V_VIS);
    endfunction

    function automatic bit m_write_ok(input int c, input int r);
        int nr;
        nr = (r == V_TOT - 1) ? 0 : r + 1;
        return !m_vis(c, r) && !((c >= H_TOT - GRD) && (nr < V_VIS));
    endfunction

    typedef enum {OP_NONE, OP_RD, OP_WR} bus_op_e;

    // Transaction decided one cycle ago (now on the pads), read decided two
    // cycles ago (now on disp_*), and the SRAM data returned one cycle ago.
    bus_op_e       m1_op = OP_NONE;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_data = '0;
    bit            m2_read = 1'b0;
    logic [DW-1:0] m_din1 = '0;
    bit            m_prev_vis = 1'b0;
    bit            mv, mrdy;
    int            mc, mr;

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        if (reset) begin
            m1_op      = OP_NONE;
            m2_read    = 1'b0;
            m_prev_vis = 1'b0;
        end else begin
            mc   = int'(column);
            mr   = int'(row);
            mv   = m_vis(mc, mr);
            // Only the cycle right after a visible one is a turnaround.
            mrdy = m_write_ok(mc, mr) && !m_prev_vis;

            check("wr_ready", 32'(bus.wr_ready), 32'(mrdy));
            check("oe_n", 32'(bus.sram_oe_n), 32'(m1_op != OP_RD));
            check("we_n", 32'(bus.sram_we_n), 32'(m1_op != OP_WR));
            check("data_oe", 32'(bus.sram_data_oe), 32'(m1_op == OP_WR));
            check("no_we_with_oe", 32'(bus.sram_we_n | bus.sram_oe_n), 32'd1);
            if (m1_op != OP_NONE) check("sram_addr", 32'(bus.sram_addr), 32'(m1_addr));
            if (m1_op == OP_WR) check("sram_data_out", 32'(bus.sram_data_out), 32'(m1_data));
            check("disp_valid", 32'(disp_valid), 32'(m2_read));
            if (m2_read) check("disp_pixel", 32'(disp_pixel), 32'(m_din1));

            m2_read = (m1_op == OP_RD);
            m_din1  = bus.sram_data_in;
            if (mv) begin
                m1_op   = OP_RD;
                m1_addr = AW'(mr * H_VIS + mc);
            end else if (mrdy && bus.wr_valid) begin
                m1_op   = OP_WR;
                m1_addr = bus.wr_addr;
                m1_data = bus.wr_data;
            end else begin
                m1_op = OP_NONE;
            end
            m_prev_vis = mv;
        end
    end

    // ---------------- stimulus ----------------
    int          acc_cnt = 0;
    logic [15:0] wseq = '0;

    // One clock: inputs change 1 time unit after the edge. The writer
    // advances to a new request only after the previous one was accepted.
    task automatic cyc(input int c, input int r, input bit wv);
        bit was_acc;
        was_acc = bus.wr_valid && bus.wr_ready;
        @(posedge clk);
        #1;
        if (was_acc) begin
            acc_cnt++;
            wseq++;
            bus.wr_data = DW'($urandom);
        end
        bus.wr_addr      = AW'(20'h80000 + 20'(wseq));
        column           = 10'(c);
        row              = 10'(r);
        bus.wr_valid     = wv;
        bus.sram_data_in = DW'($urandom);
        #1;
    endtask

    // n consecutive counter positions from (c0, r0); wmode 0 idle, 1 held, 2 toggling.
    task automatic run(input int c0, input int r0, input int n, input int wmode);
        int c, r;
        bit wv;
        c = c0;
        r = r0;
        for (int i = 0; i < n; i++) begin
            wv = (wmode == 1) || ((wmode == 2) && i[0]);
            cyc(c, r, wv);
            c++;
            if (c == H_TOT) begin
                c = 0;
                r = (r == V_TOT - 1) ? 0 : r + 1;
            end
        end
    endtask

    logic [DW-1:0] d6;
    logic [AW-1:0] a641;

    initial begin
        bus.wr_valid     = 1'b0;
        bus.wr_addr      = AW'(20'h80000);
        bus.wr_data      = DW'($urandom);
        bus.sram_data_in = '0;

        // Reset values
        #12;
        check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        check("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
        check("rst_data_oe", 32'(bus.sram_data_oe), 32'd0);
        check("rst_addr", 32'(bus.sram_addr), 32'd0);
        check("rst_data_out", 32'(bus.sram_data_out), 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_disp_pixel", 32'(disp_pixel), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;

        // (5,2): address 2*640+5 at t+1, pixel at t+2
        run(0, 2, 6, 0);
        cyc(6, 2, 1'b0);
        check("addr_5_2", 32'(bus.sram_addr), 32'd1285);
        check("oe_5_2", 32'(bus.sram_oe_n), 32'd0);
        d6 = bus.sram_data_in;
        cyc(7, 2, 1'b0);
        check("dvalid_5_2", 32'(disp_valid), 32'd1);
        check("dpix_5_2", 32'(disp_pixel), 32'(d6));

        // Line 10 blanking with the writer always valid
        run(630, 10, 10, 1);
        cyc(640, 10, 1'b1);
        check("ready_640", 32'(bus.wr_ready), 32'd0);
        acc_cnt = 0;
        cyc(641, 10, 1'b1);
        check("ready_641", 32'(bus.wr_ready), 32'd1);
        a641 = bus.wr_addr;
        cyc(642, 10, 1'b1);
        check("we_642", 32'(bus.sram_we_n), 32'd0);
        check("waddr_642", 32'(bus.sram_addr), 32'(a641));
        run(643, 10, 155, 1);
        cyc(798, 10, 1'b1);
        check("ready_798", 32'(bus.wr_ready), 32'd0);
        check("accepts_line10", 32'(acc_cnt), 32'd157);
        cyc(799, 10, 1'b1);
        check("ready_799", 32'(bus.wr_ready), 32'd0);
        check("we_799", 32'(bus.sram_we_n), 32'd1);
        cyc(0, 11, 1'b1);
        check("idle_oe_r11", 32'(bus.sram_oe_n), 32'd1);
        check("idle_we_r11", 32'(bus.sram_we_n), 32'd1);
        cyc(1, 11, 1'b1);
        check("oe_r11", 32'(bus.sram_oe_n), 32'd0);
        check("addr_r11", 32'(bus.sram_addr), 32'd7040);
        cyc(2, 11, 1'b0);

        // Last visible line into vertical blanking: continuous writes
        acc_cnt = 0;
        run(630, 479, 1770, 1);
        cyc(0, 482, 1'b0);
        check("accepts_vblank", 32'(acc_cnt), 32'd1759);

        // Frame wrap: row 523 is fully open, row 524 guards its last columns
        run(795, 523, 5, 1);
        check("ready_523_799", 32'(bus.wr_ready), 32'd1);
        run(790, 524, 8, 1);
        check("ready_524_797", 32'(bus.wr_ready), 32'd1);
        cyc(798, 524, 1'b1);
        check("ready_524_798", 32'(bus.wr_ready), 32'd0);
        cyc(799, 524, 1'b1);
        check("ready_524_799", 32'(bus.wr_ready), 32'd0);
        cyc(0, 0, 1'b1);
        check("we_wrap", 32'(bus.sram_we_n), 32'd1);
        cyc(1, 0, 1'b1);
        check("oe_wrap", 32'(bus.sram_oe_n), 32'd0);
        check("addr_wrap", 32'(bus.sram_addr), 32'd0);
        cyc(2, 0, 1'b0);

        // Row 500 with wr_valid toggling every cycle
        run(0, 500, 40, 2);

        // Reset in the middle of a write burst
        run(100, 500, 4, 1);
        check("we_before_rst", 32'(bus.sram_we_n), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("midrst_we_n", 32'(bus.sram_we_n), 32'd1);
        check("midrst_oe_n", 32'(bus.sram_oe_n), 32'd1);
        check("midrst_data_oe", 32'(bus.sram_data_oe), 32'd0);
        check("midrst_disp_valid", 32'(disp_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        run(795, 524, 5, 1);
        check("ready_guard_after_rst", 32'(bus.wr_ready), 32'd0);
        cyc(0, 0, 1'b1);
        cyc(1, 0, 1'b1);
        check("oe_after_rst", 32'(bus.sram_oe_n), 32'd0);
        check("addr_after_rst", 32'(bus.sram_addr), 32'd0);
        cyc(2, 0, 1'b1);
        check("dvalid_after_rst", 32'(disp_valid), 32'd1);
        run(3, 0, 4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
